// File: rtl/ring_router_vc.sv
// Bidirectional ring router: cw, ccw and pe ports, each with even/odd virtual channels.
// Links serve the VC equal to polarity while the internal switch serves the other VC.
module ring_router_vc #(
    parameter int DATA_W  = 64,
    parameter int DIR_BIT = 30,
    parameter int HOP_LSB = 18,
    parameter int HOP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cwsi,
    output logic              cwri,
    input  logic [DATA_W-1:0] cwdi,
    input  logic              ccwsi,
    output logic              ccwri,
    input  logic [DATA_W-1:0] ccwdi,
    input  logic              pesi,
    output logic              peri,
    input  logic [DATA_W-1:0] pedi,
    output logic              cwso,
    input  logic              cwro,
    output logic [DATA_W-1:0] cwdo,
    output logic              ccwso,
    input  logic              ccwro,
    output logic [DATA_W-1:0] ccwdo,
    output logic              peso,
    input  logic              pero,
    output logic [DATA_W-1:0] pedo,
    output logic              polarity
);
    localparam int NP  = 3;
    localparam int CW  = 0;
    localparam int CCW = 1;
    localparam int PE  = 2;

    logic [NP-1:0]     link_send;
    logic [NP-1:0]     link_ready;
    logic [DATA_W-1:0] link_data [NP];
    logic [NP-1:0]     in_ready;
    logic [NP-1:0]     in_load;
    logic [NP-1:0]     out_send;
    logic [NP-1:0]     out_drain;
    logic [DATA_W-1:0] out_link_data [NP];

    logic [1:0]        in_full  [NP];
    logic [DATA_W-1:0] in_data  [NP][2];
    logic [1:0]        out_full [NP];
    logic [DATA_W-1:0] out_data [NP][2];
    logic [1:0]        prio     [NP];

    logic              sw_vc;
    logic [NP-1:0]     sw_req;
    logic [1:0]        route    [NP];
    logic [DATA_W-1:0] sw_data  [NP];
    logic [NP-1:0]     grant_a;
    logic [NP-1:0]     grant_b;
    logic [NP-1:0]     sw_load;
    logic [NP-1:0]     prio_flip;
    logic [NP-1:0]     in_pop;
    logic [DATA_W-1:0] sw_out   [NP];

    function automatic logic [DATA_W-1:0] hop_step(input logic [DATA_W-1:0] pkt);
        logic [DATA_W-1:0] r;
        r = pkt;
        r[HOP_LSB +: HOP_W] = pkt[HOP_LSB +: HOP_W] >> 1;
        return r;
    endfunction

    assign link_send  = {pesi, ccwsi, cwsi};
    assign link_ready = {pero, ccwro, cwro};
    assign link_data[CW]  = cwdi;
    assign link_data[CCW] = ccwdi;
    assign link_data[PE]  = pedi;

    assign sw_vc = ~polarity;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            logic [DATA_W-1:0] head;

            assign in_ready[gi]      = ~in_full[gi][polarity];
            assign in_load[gi]       = link_send[gi] & in_ready[gi];
            assign out_send[gi]      = out_full[gi][polarity];
            assign out_drain[gi]     = out_send[gi] & link_ready[gi];
            assign out_link_data[gi] = out_send[gi] ? out_data[gi][polarity] : '0;

            assign head       = in_data[gi][sw_vc];
            assign sw_req[gi] = in_full[gi][sw_vc];
            if (gi == PE) begin : g_inject
                assign route[gi]   = head[DIR_BIT] ? 2'(CCW) : 2'(CW);
                assign sw_data[gi] = head;
            end else begin : g_ring
                // Hop LSB clear means this router is the destination.
                assign route[gi]   = head[HOP_LSB] ? 2'(gi) : 2'(PE);
                assign sw_data[gi] = head[HOP_LSB] ? hop_step(head) : head;
            end
        end

        for (gi = 0; gi < NP; gi++) begin : g_arb
            // Contender A wins ties while the priority bit is 0.
            localparam int SRC_A = (gi == PE) ? CW  : gi;
            localparam int SRC_B = (gi == PE) ? CCW : PE;
            logic req_a;
            logic req_b;
            logic free;

            assign req_a         = sw_req[SRC_A] && (route[SRC_A] == 2'(gi));
            assign req_b         = sw_req[SRC_B] && (route[SRC_B] == 2'(gi));
            assign free          = ~out_full[gi][sw_vc];
            assign grant_a[gi]   = free & req_a & (~req_b | ~prio[gi][sw_vc]);
            assign grant_b[gi]   = free & req_b & (~req_a |  prio[gi][sw_vc]);
            assign sw_load[gi]   = grant_a[gi] | grant_b[gi];
            assign prio_flip[gi] = free & req_a & req_b;
            assign sw_out[gi]    = grant_a[gi] ? sw_data[SRC_A] : sw_data[SRC_B];
        end
    endgenerate

    // Each input requests exactly one output, so at most one of these terms is set.
    assign in_pop[CW]  = grant_a[CW]  | grant_a[PE];
    assign in_pop[CCW] = grant_a[CCW] | grant_b[PE];
    assign in_pop[PE]  = grant_b[CW]  | grant_b[CCW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            polarity <= 1'b0;
            for (int i = 0; i < NP; i++) begin
                in_full[i]  <= '0;
                out_full[i] <= '0;
                prio[i]     <= '0;
                for (int v = 0; v < 2; v++) begin
                    in_data[i][v]  <= '0;
                    out_data[i][v] <= '0;
                end
            end
        end else begin
            polarity <= ~polarity;
            for (int i = 0; i < NP; i++) begin
                if (in_load[i]) begin
                    in_full[i][polarity] <= 1'b1;
                    in_data[i][polarity] <= link_data[i];
                end
                if (in_pop[i]) begin
                    in_full[i][sw_vc] <= 1'b0;
                end
                if (out_drain[i]) begin
                    out_full[i][polarity] <= 1'b0;
                end
                if (sw_load[i]) begin
                    out_full[i][sw_vc] <= 1'b1;
                    out_data[i][sw_vc] <= sw_out[i];
                end
                if (prio_flip[i]) begin
                    prio[i][sw_vc] <= ~prio[i][sw_vc];
                end
            end
        end
    end

    assign cwri  = in_ready[CW];
    assign ccwri = in_ready[CCW];
    assign peri  = in_ready[PE];
    assign cwso  = out_send[CW];
    assign ccwso = out_send[CCW];
    assign peso  = out_send[PE];
    assign cwdo  = out_link_data[CW];
    assign ccwdo = out_link_data[CCW];
    assign pedo  = out_link_data[PE];
endmodule

// File: tb/tb_ring_router_vc.sv
// Bench for ring_router_vc: directed scenarios plus random traffic against a
// transaction-level model of buffers, routing rules and round-robin arbitration.
module tb_ring_router_vc;
    localparam int DATA_W  = 64;
    localparam int DIR_BIT = 30;
    localparam int HOP_LSB = 18;
    localparam int HOP_W   = 8;

    logic clk = 1'b0;
    logic reset;
    logic cwsi, ccwsi, pesi, cwro, ccwro, pero;
    logic [DATA_W-1:0] cwdi, ccwdi, pedi;
    logic cwri, ccwri, peri, cwso, ccwso, peso, polarity;
    logic [DATA_W-1:0] cwdo, ccwdo, pedo;

    always #5 clk = ~clk;

    ring_router_vc #(.DATA_W(DATA_W), .DIR_BIT(DIR_BIT), .HOP_LSB(HOP_LSB), .HOP_W(HOP_W)) dut (
        .clk(clk), .reset(reset),
        .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
        .ccwsi(ccwsi), .ccwri(ccwri), .ccwdi(ccwdi),
        .pesi(pesi), .peri(peri), .pedi(pedi),
        .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
        .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo),
        .peso(peso), .pero(pero), .pedo(pedo),
        .polarity(polarity)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: ports 0=cw 1=ccw 2=pe, index [port][vc]
    bit          m_pol;
    bit          m_in_full  [3][2];
    logic [63:0] m_in_data  [3][2];
    bit          m_out_full [3][2];
    logic [63:0] m_out_data [3][2];
    bit          m_prio     [3][2];

    task automatic model_reset();
        m_pol = 0;
        for (int x = 0; x < 3; x++)
            for (int v = 0; v < 2; v++) begin
                m_in_full[x][v] = 0; m_out_full[x][v] = 0; m_prio[x][v] = 0;
                m_in_data[x][v] = '0; m_out_data[x][v] = '0;
            end
    endtask

    function automatic int dest_of(input int src, input logic [63:0] p);
        if (src == 2) return p[DIR_BIT] ? 1 : 0;
        return p[HOP_LSB] ? src : 2;
    endfunction

    task automatic model_step(input bit [2:0] snd, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input bit [2:0] rdy);
        int v, p, a, b, w;
        bit ra, rb;
        bit taken [3];
        logic [63:0] pk;
        logic [63:0] ld [3];
        v = m_pol ? 0 : 1;
        p = m_pol ? 1 : 0;
        ld[0] = d0; ld[1] = d1; ld[2] = d2;
        for (int x = 0; x < 3; x++) taken[x] = 0;
        for (int o = 0; o < 3; o++) begin
            a  = (o == 2) ? 0 : o;
            b  = (o == 2) ? 1 : 2;
            ra = m_in_full[a][v] && dest_of(a, m_in_data[a][v]) == o;
            rb = m_in_full[b][v] && dest_of(b, m_in_data[b][v]) == o;
            w  = -1;
            if (!m_out_full[o][v]) begin
                if (ra && rb) begin
                    w = m_prio[o][v] ? b : a;
                    m_prio[o][v] = !m_prio[o][v];
                end else if (ra) w = a;
                else if (rb) w = b;
            end
            if (w >= 0) begin
                pk = m_in_data[w][v];
                if (w != 2 && pk[HOP_LSB]) pk[HOP_LSB +: HOP_W] = pk[HOP_LSB +: HOP_W] >> 1;
                m_out_full[o][v] = 1;
                m_out_data[o][v] = pk;
                taken[w] = 1;
            end
        end
        for (int x = 0; x < 3; x++) begin
            if (taken[x]) m_in_full[x][v] = 0;
            if (m_out_full[x][p] && rdy[x]) m_out_full[x][p] = 0;
            if (snd[x] && !m_in_full[x][p]) begin
                m_in_full[x][p] = 1;
                m_in_data[x][p] = ld[x];
            end
        end
        m_pol = !m_pol;
    endtask

    bit rec_en = 0;
    logic [63:0] got_even[$], got_odd[$], exp_even[$], exp_odd[$];

    task automatic tick();
        @(negedge clk);
        check("polarity", polarity, m_pol);
        check("cwri",  cwri,  !m_in_full[0][m_pol]);
        check("ccwri", ccwri, !m_in_full[1][m_pol]);
        check("peri",  peri,  !m_in_full[2][m_pol]);
        check("cwso",  cwso,  m_out_full[0][m_pol]);
        check("ccwso", ccwso, m_out_full[1][m_pol]);
        check("peso",  peso,  m_out_full[2][m_pol]);
        check("cwdo",  cwdo,  m_out_full[0][m_pol] ? m_out_data[0][m_pol] : 64'h0);
        check("ccwdo", ccwdo, m_out_full[1][m_pol] ? m_out_data[1][m_pol] : 64'h0);
        check("pedo",  pedo,  m_out_full[2][m_pol] ? m_out_data[2][m_pol] : 64'h0);
        if (rec_en && cwso && cwro) begin
            if (polarity) got_odd.push_back(cwdo);
            else got_even.push_back(cwdo);
        end
        @(posedge clk);
        if (!reset) model_step({pesi, ccwsi, cwsi}, cwdi, ccwdi, pedi, {pero, ccwro, cwro});
        #1;
    endtask

    task automatic idle_inputs();
        cwsi = 0; ccwsi = 0; pesi = 0;
        cwdi = '0; ccwdi = '0; pedi = '0;
        cwro = 1; ccwro = 1; pero = 1;
    endtask

    task automatic wait_pol0();
        for (int i = 0; i < 2; i++) if (m_pol) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cwri"}, cwri, 1);   check({tag, "_ccwri"}, ccwri, 1); check({tag, "_peri"}, peri, 1);
        check({tag, "_cwso"}, cwso, 0);   check({tag, "_ccwso"}, ccwso, 0); check({tag, "_peso"}, peso, 0);
        check({tag, "_cwdo"}, cwdo, 0);   check({tag, "_ccwdo"}, ccwdo, 0); check({tag, "_pedo"}, pedo, 0);
        check({tag, "_pol"}, polarity, 0);
    endtask

    task automatic polarity_sequence(input string tag);
        for (int k = 0; k < 4; k++) begin
            check(tag, polarity, k % 2);
            tick();
        end
    endtask

    function automatic logic [63:0] rand_pkt();
        logic [63:0] p;
        p = {$urandom, $urandom};
        p[HOP_LSB +: HOP_W] = 8'($urandom_range(0, 5));
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] pk;
        int ne, no;
        reset = 1;
        idle_inputs();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("rst_init");
        reset = 0;
        polarity_sequence("pol_seq_init");

        // Eject: hop 0 on cw input lands on pe output
        wait_pol0();
        cwsi = 1; cwdi = 64'h0000_0000_0000_1234;
        tick();
        cwsi = 0;
        tick();
        check("eject_peso", peso, 1);
        check("eject_pedo", pedo, 64'h0000_0000_0000_1234);
        check("eject_cwso", cwso, 0);
        repeat (4) tick();

        // Forward: hop 3 leaves on cw with hop 1
        wait_pol0();
        cwsi = 1; cwdi = 64'hA5A5_0000_000C_0000;
        tick();
        cwsi = 0;
        tick();
        check("fwd_cwso", cwso, 1);
        check("fwd_cwdo", cwdo, 64'hA5A5_0000_0004_0000);
        check("fwd_peso", peso, 0);
        repeat (4) tick();

        // Inject: dir bit 1 goes to ccw unmodified
        wait_pol0();
        pesi = 1; pedi = 64'h0000_0077_4014_0000;
        tick();
        pesi = 0;
        tick();
        check("inj_ccwso", ccwso, 1);
        check("inj_ccwdo", ccwdo, 64'h0000_0077_4014_0000);
        check("inj_cwso", cwso, 0);
        repeat (4) tick();

        // Contention on pe output, twice
        wait_pol0();
        cwsi = 1; cwdi = 64'h0000_00C1_0000_0000;
        ccwsi = 1; ccwdi = 64'h0000_00CC_0000_0000;
        tick();
        cwsi = 0; ccwsi = 0;
        tick();
        check("cont1_first", pedo, 64'h0000_00C1_0000_0000);
        tick(); tick();
        check("cont1_second", pedo, 64'h0000_00CC_0000_0000);
        repeat (4) tick();
        wait_pol0();
        cwsi = 1; cwdi = 64'h0000_00C2_0000_0000;
        ccwsi = 1; ccwdi = 64'h0000_00CD_0000_0000;
        tick();
        cwsi = 0; ccwsi = 0;
        tick();
        check("cont2_first", pedo, 64'h0000_00CD_0000_0000);
        tick(); tick();
        check("cont2_second", pedo, 64'h0000_00C2_0000_0000);
        repeat (4) tick();

        // Backpressure on even cw output while the odd VC keeps moving
        wait_pol0();
        ne = 0; no = 0;
        rec_en = 1;
        for (int c = 0; c < 24; c++) begin
            cwro = m_pol;
            cwsi = 1;
            if (m_pol) cwdi = {32'h0D0D_0000 | 32'(no), 32'h0004_0000};
            else       cwdi = {32'hE0E0_0000 | 32'(ne), 32'h0004_0000};
            if (c >= 16) begin
                if (m_pol) check("bp_cwri_odd", cwri, 1);
                else       check("bp_cwri_even", cwri, 0);
            end
            if (cwri) begin
                pk = {cwdi[63:32], 32'h0};
                if (m_pol) begin exp_odd.push_back(pk); no++; end
                else begin exp_even.push_back(pk); ne++; end
            end
            tick();
        end
        cwsi = 0; cwro = 1;
        repeat (8) tick();
        rec_en = 0;
        check("bp_even_count", got_even.size(), exp_even.size());
        check("bp_odd_count", got_odd.size(), exp_odd.size());
        for (int i = 0; i < exp_even.size() && i < got_even.size(); i++) check("bp_even_data", got_even[i], exp_even[i]);
        for (int i = 0; i < exp_odd.size() && i < got_odd.size(); i++) check("bp_odd_data", got_odd[i], exp_odd[i]);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            cwsi = $urandom_range(0, 1); ccwsi = $urandom_range(0, 1); pesi = $urandom_range(0, 1);
            cwdi = rand_pkt(); ccwdi = rand_pkt(); pedi = rand_pkt();
            cwro = ($urandom_range(0, 3) != 0); ccwro = ($urandom_range(0, 3) != 0); pero = ($urandom_range(0, 3) != 0);
            tick();
            if (c == 1500) begin
                // Fill buffers, then reset asynchronously mid-cycle
                cwro = 0; ccwro = 0; pero = 0;
                cwsi = 1; ccwsi = 1; pesi = 1;
                repeat (12) begin
                    cwdi = rand_pkt(); ccwdi = rand_pkt(); pedi = rand_pkt();
                    tick();
                end
                #2;
                reset = 1;
                #1;
                check_reset_outputs("rst_mid");
                model_reset();
                idle_inputs();
                tick();
                reset = 0;
                polarity_sequence("pol_seq_mid");
            end
        end

        idle_inputs();
        repeat (6) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ring_router_vc.md
Name: ring_router_vc

Overview:
- Parametrised bidirectional ring router with three ports: clockwise (cw), counter-clockwise (ccw) and processing element (pe).
- Each port has two virtual channels, even and odd, each with a one-entry input buffer and a one-entry output buffer.
- An internal polarity bit time-multiplexes the channels. External links move the VC equal to polarity; the internal switch moves the other VC.
- Packets route by a direction bit and a shift-encoded hop field in the header. Per-output, per-VC round-robin arbitration resolves contention.

Parameters:
- DATA_W, 64, packet width in bits.
- DIR_BIT, 30, header bit position: 0 = clockwise, 1 = counter-clockwise. Used only for PE injection.
- HOP_LSB, 18, LSB position of the hop field.
- HOP_W, 8, hop field width; HOP_LSB+HOP_W <= DATA_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cwsi  in  1  cw link send
- cwri  out  1  cw link ready
- cwdi  in  DATA_W  cw link data
- ccwsi  in  1  ccw link send
- ccwri  out  1  ccw link ready
- ccwdi  in  DATA_W  ccw link data
- pesi  in  1  PE inject send
- peri  out  1  PE inject ready
- pedi  in  DATA_W  PE inject data
- cwso  out  1  cw out send
- cwro  in  1  cw out ready
- cwdo  out  DATA_W  cw out data
- ccwso  out  1  ccw out send
- ccwro  in  1  ccw out ready
- ccwdo  out  DATA_W  ccw out data
- peso  out  1  PE eject send
- pero  in  1  PE eject ready
- pedo  out  DATA_W  PE eject data
- polarity  out  1  current external VC (0 = even, 1 = odd)

Behaviour:
- Reset (async, any time including mid-packet):
  - polarity=0; all 12 buffers empty; data registers cleared; arbitration priorities at their reset values.
  - Outputs: xri=1, xso=0, xdo=0.
  - In-flight packets are discarded.
- Polarity: toggles on every clk edge out of reset.
- Input side, VC = polarity:
  - xri = input buffer[polarity] empty (combinational from flops).
  - When xsi && xri, xdi is written into buffer[polarity] at the edge.
  - When xsi=1 and xri=0, the input is ignored; the sender holds.
- Output side, VC = polarity:
  - xso = output buffer[polarity] full; xdo = output buffer[polarity] data, else 0.
  - When xso && xro, buffer[polarity] empties at the edge.
- Internal switch, VC v = ~polarity, evaluated each cycle from full input buffers[v].
- Routing, cw input (ccw input symmetric):
  - If hop[HOP_LSB]==0, the packet requests the pe output.
  - Otherwise it requests the cw output (ccw output for ccw input), with the hop field logically shifted right by 1. All other bits are unchanged.
- Routing, pe input: requests cw output if bit DIR_BIT==0, else ccw output. The header is unmodified.
- Contention and arbitration:
  - cw out is contended by cw-in vs pe-in; ccw out by ccw-in vs pe-in; pe out by cw-in vs ccw-in.
  - One priority bit per output per VC (6 total). Reset favours cw-in for cw out, ccw-in for ccw out, and cw-in for pe out.
  - The priority bit flips only when both requestors are present and a grant occurs.
- Transfer condition: a grant and transfer happen only if output buffer[v] is empty.
  - At the edge the packet is written to output buffer[v] and input buffer[v] is emptied.
  - A loser, or a packet blocked by a full output, stays in place and retries on the next v slot (2 cycles later).
- No hazards exist between switch and link: links touch only VC polarity and the switch touches only VC ~polarity.
- A single input buffer can be granted to only one output; all three outputs may be granted in the same cycle.
- Latency: a packet accepted at edge E moves through the switch at E+1. xso is asserted in the cycle after E+1, and the earliest drain is at edge E+2.
- Sustained throughput: one packet per VC per 2 cycles per port, i.e. a full link rate of 1/cycle.

Test Plan:
- Reset: assert reset mid-run with packets in all buffers. Required: cwri=ccwri=peri=1, all so=0, all do=0, polarity=0. After release, polarity toggles 0,1,0,1.
- Eject: at polarity=0, drive cwsi=1 with cwdi=64'h0000_0000_0000_1234 (hop=0), pero=1. Required: peso=1 with pedo=64'h...1234 in the cycle after edge E+1 (polarity=0). No cwso.
- Forward: cwdi with hop=8'h03 (bits 25:18) and bit30=0. Required: cwso=1 two edges later; cwdo has hop=8'h01 and all other bits identical.
- Inject: pesi=1 with pedi bit30=1, hop=8'h05. Required: ccwso=1 with pedi unmodified (hop still 8'h05). cwso stays 0.
- Contention: cw-in and ccw-in both hop=0, same VC, same edge. Required: the cw packet appears on pedo first. The ccw packet follows on the next same-VC slot (2 cycles later) and the priority bit flips. Repeating the scenario must grant ccw first.
- Backpressure: hold cwro=0 and stream cw-forward packets on the even VC. Required: even output fills, then even input fills, then cwri=0 in polarity=0 cycles only. The odd VC keeps flowing. Raising cwro drains packets in order with none lost or duplicated.
